loom_axil_arbiter: RTL

N:1 AXI-Lite arbiter that merges several AXI-Lite masters (host bridge, debug/JTAG bridge, DMA) onto the single AXI-Lite slave port of the Loom address demux. It runs independent round-robin arbitration for the read and write channels, with one outstanding transaction per channel. A granted master keeps the channel until its response handshake completes.

---
 rtl/loom_axil_pkg.sv | 19 +
 rtl/loom_rr_arbiter.sv | 31 +++
 rtl/loom_axil_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/loom_axil_pkg.sv
// rtl/loom_axil_pkg.sv - AXI-Lite response codes and arbiter FSM state types
package loom_axil_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ADDR,
        RD_RESP
    } rd_state_e;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_XFER,
        WR_RESP
    } wr_state_e;

endpackage

// File: rtl/loom_rr_arbiter.sv
// rtl/loom_rr_arbiter.sv - combinational round-robin search starting at ptr
module loom_rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]                   req,
    input  logic [(N > 1 ? $clog2(N) : 1)-1:0] ptr,
    input  logic                           en,
    output logic [(N > 1 ? $clog2(N) : 1)-1:0] gnt_idx,
    output logic                           gnt_valid
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    always_comb begin
        int k;
        k         = 0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (en && !gnt_valid && req[k]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IW'(k);
            end
        end
    end

endmodule

// File: rtl/loom_axil_arbiter.sv
// rtl/loom_axil_arbiter.sv - N:1 AXI-Lite arbiter with independent round-robin read and write channels
module loom_axil_arbiter
    import loom_axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 20,
    parameter int N_SLAVES   = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [N_SLAVES*ADDR_WIDTH-1:0] s_axil_araddr_i,
    input  logic [N_SLAVES-1:0]            s_axil_arvalid_i,
    output logic [N_SLAVES-1:0]            s_axil_arready_o,
    output logic [N_SLAVES*32-1:0]         s_axil_rdata_o,
    output logic [N_SLAVES*2-1:0]          s_axil_rresp_o,
    output logic [N_SLAVES-1:0]            s_axil_rvalid_o,
    input  logic [N_SLAVES-1:0]            s_axil_rready_i,
    input  logic [N_SLAVES*ADDR_WIDTH-1:0] s_axil_awaddr_i,
    input  logic [N_SLAVES-1:0]            s_axil_awvalid_i,
    output logic [N_SLAVES-1:0]            s_axil_awready_o,
    input  logic [N_SLAVES*32-1:0]         s_axil_wdata_i,
    input  logic [N_SLAVES*4-1:0]          s_axil_wstrb_i,
    input  logic [N_SLAVES-1:0]            s_axil_wvalid_i,
    output logic [N_SLAVES-1:0]            s_axil_wready_o,
    output logic [N_SLAVES*2-1:0]          s_axil_bresp_o,
    output logic [N_SLAVES-1:0]            s_axil_bvalid_o,
    input  logic [N_SLAVES-1:0]            s_axil_bready_i,
    output logic [ADDR_WIDTH-1:0]          m_axil_araddr_o,
    output logic                           m_axil_arvalid_o,
    input  logic                           m_axil_arready_i,
    input  logic [31:0]                    m_axil_rdata_i,
    input  logic [1:0]                     m_axil_rresp_i,
    input  logic                           m_axil_rvalid_i,
    output logic                           m_axil_rready_o,
    output logic [ADDR_WIDTH-1:0]          m_axil_awaddr_o,
    output logic                           m_axil_awvalid_o,
    input  logic                           m_axil_awready_i,
    output logic [31:0]                    m_axil_wdata_o,
    output logic [3:0]                     m_axil_wstrb_o,
    output logic                           m_axil_wvalid_o,
    input  logic                           m_axil_wready_i,
    input  logic [1:0]                     m_axil_bresp_i,
    input  logic                           m_axil_bvalid_i,
    output logic                           m_axil_bready_o
);

    localparam int IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        if (int'(idx) >= N_SLAVES - 1) begin
            return '0;
        end
        return idx + IW'(1);
    endfunction

    rd_state_e     rd_state, rd_state_d;
    logic [IW-1:0] rd_gnt, rd_gnt_d, rd_ptr, rd_ptr_d, rd_arb_idx;
    logic          rd_arb_valid;

    wr_state_e     wr_state, wr_state_d;
    logic [IW-1:0] wr_gnt, wr_gnt_d, wr_ptr, wr_ptr_d, wr_arb_idx;
    logic          wr_arb_valid;
    logic          aw_done, aw_done_d, w_done, w_done_d;

    loom_rr_arbiter #(.N(N_SLAVES)) u_rd_arb (
        .req       (s_axil_arvalid_i),
        .ptr       (rd_ptr),
        .en        (rd_state == RD_IDLE),
        .gnt_idx   (rd_arb_idx),
        .gnt_valid (rd_arb_valid)
    );

    loom_rr_arbiter #(.N(N_SLAVES)) u_wr_arb (
        .req       (s_axil_awvalid_i),
        .ptr       (wr_ptr),
        .en        (wr_state == WR_IDLE),
        .gnt_idx   (wr_arb_idx),
        .gnt_valid (wr_arb_valid)
    );

    // Payloads follow the registered grant; only the valids are state-gated.
    assign m_axil_araddr_o = s_axil_araddr_i[int'(rd_gnt)*ADDR_WIDTH +: ADDR_WIDTH];
    assign m_axil_awaddr_o = s_axil_awaddr_i[int'(wr_gnt)*ADDR_WIDTH +: ADDR_WIDTH];
    assign m_axil_wdata_o  = s_axil_wdata_i[int'(wr_gnt)*32 +: 32];
    assign m_axil_wstrb_o  = s_axil_wstrb_i[int'(wr_gnt)*4 +: 4];
    assign s_axil_rdata_o  = {N_SLAVES{m_axil_rdata_i}};
    assign s_axil_rresp_o  = {N_SLAVES{m_axil_rresp_i}};
    assign s_axil_bresp_o  = {N_SLAVES{m_axil_bresp_i}};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_state <= RD_IDLE;
            rd_gnt   <= '0;
            rd_ptr   <= '0;
        end else begin
            rd_state <= rd_state_d;
            rd_gnt   <= rd_gnt_d;
            rd_ptr   <= rd_ptr_d;
        end
    end

    always_comb begin
        rd_state_d       = rd_state;
        rd_gnt_d         = rd_gnt;
        rd_ptr_d         = rd_ptr;
        m_axil_arvalid_o = 1'b0;
        m_axil_rready_o  = 1'b0;
        s_axil_arready_o = '0;
        s_axil_rvalid_o  = '0;
        case (rd_state)
            RD_IDLE: begin
                if (rd_arb_valid) begin
                    rd_gnt_d   = rd_arb_idx;
                    rd_state_d = RD_ADDR;
                end
            end
            RD_ADDR: begin
                m_axil_arvalid_o         = s_axil_arvalid_i[rd_gnt];
                s_axil_arready_o[rd_gnt] = m_axil_arready_i;
                if (s_axil_arvalid_i[rd_gnt] && m_axil_arready_i) begin
                    rd_ptr_d   = next_idx(rd_gnt);
                    rd_state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                s_axil_rvalid_o[rd_gnt] = m_axil_rvalid_i;
                m_axil_rready_o         = s_axil_rready_i[rd_gnt];
                if (m_axil_rvalid_i && s_axil_rready_i[rd_gnt]) begin
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_state <= WR_IDLE;
            wr_gnt   <= '0;
            wr_ptr   <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            wr_state <= wr_state_d;
            wr_gnt   <= wr_gnt_d;
            wr_ptr   <= wr_ptr_d;
            aw_done  <= aw_done_d;
            w_done   <= w_done_d;
        end
    end

    always_comb begin
        wr_state_d       = wr_state;
        wr_gnt_d         = wr_gnt;
        wr_ptr_d         = wr_ptr;
        aw_done_d        = aw_done;
        w_done_d         = w_done;
        m_axil_awvalid_o = 1'b0;
        m_axil_wvalid_o  = 1'b0;
        m_axil_bready_o  = 1'b0;
        s_axil_awready_o = '0;
        s_axil_wready_o  = '0;
        s_axil_bvalid_o  = '0;
        case (wr_state)
            WR_IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (wr_arb_valid) begin
                    wr_gnt_d   = wr_arb_idx;
                    wr_state_d = WR_XFER;
                end
            end
            WR_XFER: begin
                // AW and W complete in either order; each is masked once accepted.
                m_axil_awvalid_o         = s_axil_awvalid_i[wr_gnt] && !aw_done;
                m_axil_wvalid_o          = s_axil_wvalid_i[wr_gnt] && !w_done;
                s_axil_awready_o[wr_gnt] = m_axil_awready_i && !aw_done;
                s_axil_wready_o[wr_gnt]  = m_axil_wready_i && !w_done;
                aw_done_d = aw_done || (m_axil_awvalid_o && m_axil_awready_i);
                w_done_d  = w_done || (m_axil_wvalid_o && m_axil_wready_i);
                if (aw_done_d && w_done_d) begin
                    wr_ptr_d   = next_idx(wr_gnt);
                    wr_state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                s_axil_bvalid_o[wr_gnt] = m_axil_bvalid_i;
                m_axil_bready_o         = s_axil_bready_i[wr_gnt];
                if (m_axil_bvalid_i && s_axil_bready_i[wr_gnt]) begin
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

endmodule
